// File: rtl/fila_resposta_uart_pkg.sv
// Purpose: shared types for the sensor/UART response path (FSM states, byte width, response pair).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fila_resposta_uart_pkg;

    localparam int BYTE_W = 8;
    localparam int PAR_W  = 2 * BYTE_W;

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        ENVIA_CMD  = 3'd1,
        ESPERA_CMD = 3'd2,
        ENVIA_VAL  = 3'd3,
        ESPERA_VAL = 3'd4
    } estado_t;

    // Command byte in the upper half, value byte in the lower half.
    typedef struct packed {
        logic [BYTE_W-1:0] cmd;
        logic [BYTE_W-1:0] val;
    } par_t;

endpackage

// File: rtl/fila_resposta_uart_fila_sincrona.sv
// Purpose: synchronous circular FIFO with occupancy count.
// Latency: write visible at head one cycle after push; head is combinational from storage.
// Backpressure: push dropped when full unless a pop happens in the same cycle.
//
// Ports: clock/reset (async active-low), i_push/i_dat write side, i_pop read side,
//        o_head current head word, o_count occupancy, o_full/o_empty status.
module fila_sincrona #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_dat,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_do_pop = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fila_resposta_uart.sv
// Purpose: buffers sensor response pairs and feeds them to a UART, command byte then value byte.
// Latency: push into empty buffer with idle UART -> tx_start two cycles after the push edge.
// Backpressure: waits on tx_busy before each pair/value byte; pushes into a full buffer are dropped (sticky overflow).
//
// Ports: clock, reset (async active-low); dados_prontos/response_command/response_value from the
//        sensor stage; tx_busy/tx_done from the UART; tx_start/tx_data to the UART;
//        fila_count occupancy, overflow sticky drop flag.
module fila_resposta_uart
    import fila_resposta_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   dados_prontos,
    input  logic [BYTE_W-1:0]      response_command,
    input  logic [BYTE_W-1:0]      response_value,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic                   tx_start,
    output logic [BYTE_W-1:0]      tx_data,
    output logic [$clog2(DEPTH):0] fila_count,
    output logic                   overflow
);

    estado_t          r_state;
    estado_t          w_next;
    logic             r_dp_prev;
    logic             r_overflow;

    logic             w_push;
    logic             w_pop;
    logic [PAR_W-1:0] w_head_dat;
    par_t             w_head;
    logic             w_full;
    logic             w_empty;

    assign w_push   = dados_prontos && !r_dp_prev;
    // The head pair leaves only once its value byte has fully gone out.
    assign w_pop    = (r_state == ESPERA_VAL) && tx_done;
    assign w_head   = par_t'(w_head_dat);
    assign overflow = r_overflow;

    fila_sincrona #(
        .WIDTH (PAR_W),
        .DEPTH (DEPTH)
    ) u_fila (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_dat   ({response_command, response_value}),
        .i_pop   (w_pop),
        .o_head  (w_head_dat),
        .o_count (fila_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= OCIOSO;
            r_dp_prev  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dp_prev <= dados_prontos;
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // tx_data follows the head pair from the start request until its tx_done;
    // the head cannot change meanwhile because pops only happen at the end of a pair.
    always_comb begin
        w_next   = r_state;
        tx_start = 1'b0;
        tx_data  = '0;
        case (r_state)
            OCIOSO: begin
                if (!w_empty && !tx_busy) w_next = ENVIA_CMD;
            end
            ENVIA_CMD: begin
                tx_start = 1'b1;
                tx_data  = w_head.cmd;
                w_next   = ESPERA_CMD;
            end
            ESPERA_CMD: begin
                tx_data = w_head.cmd;
                if (tx_done) w_next = ENVIA_VAL;
            end
            ENVIA_VAL: begin
                tx_data = w_head.val;
                if (!tx_busy) begin
                    tx_start = 1'b1;
                    w_next   = ESPERA_VAL;
                end
            end
            ESPERA_VAL: begin
                tx_data = w_head.val;
                if (tx_done) w_next = OCIOSO;
            end
            default: w_next = OCIOSO;
        endcase
    end

endmodule

// File: tb/tb_fila_resposta_uart.sv
module tb_fila_resposta_uart;
    import fila_resposta_uart_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          dados_prontos = 1'b0;
    logic [7:0]    response_command = 8'h00;
    logic [7:0]    response_value = 8'h00;
    logic          tx_busy = 1'b0;
    logic          tx_done = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic [CW-1:0] fila_count;
    logic          overflow;

    fila_resposta_uart #(.DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .dados_prontos    (dados_prontos),
        .response_command (response_command),
        .response_value   (response_value),
        .tx_busy          (tx_busy),
        .tx_done          (tx_done),
        .tx_start         (tx_start),
        .tx_data          (tx_data),
        .fila_count       (fila_count),
        .overflow         (overflow)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: stored pairs, expected byte stream, sticky drop flag.
    logic [15:0] mq[$];
    logic [7:0]  exp_bytes[$];
    bit          m_prev;
    bit          m_ovf;

    // UART responder state.
    bit          force_busy;
    bit          in_flight;
    bit          done_is_val;
    int          timer;
    int          got_n;
    logic [7:0]  cur_byte;
    logic [7:0]  last_byte;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] val;
        int         exp_cnt;
        bit         exp_ovf;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic tick();
        #1;
        if (in_flight) begin
            check("start_while_busy", {31'd0, tx_start}, 32'd0);
            check("data_stable", {24'd0, tx_data}, {24'd0, cur_byte});
        end else if (tx_start === 1'b1) begin
            total++;
            if (got_n >= exp_bytes.size()) begin
                bad++;
                $display("FAIL spurious_start: got byte %02h, none expected", tx_data);
            end else if (tx_data !== exp_bytes[got_n]) begin
                bad++;
                $display("FAIL byte_order: byte %0d got %02h want %02h", got_n, tx_data, exp_bytes[got_n]);
            end
            cur_byte  = tx_data;
            last_byte = tx_data;
            got_n++;
            in_flight = 1'b1;
            timer     = int'($urandom_range(1, 4));
        end
        // Model the coming edge: pop (end of a value byte) first, then push.
        if (tx_done && done_is_val) void'(mq.pop_front());
        if (dados_prontos && !m_prev) begin
            if (mq.size() < DEPTH) begin
                mq.push_back({response_command, response_value});
                exp_bytes.push_back(response_command);
                exp_bytes.push_back(response_value);
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_prev = dados_prontos;
        @(posedge clock);
        #1;
        tx_done = 1'b0;
        if (in_flight) begin
            if (timer == 0) begin
                tx_done     = 1'b1;
                in_flight   = 1'b0;
                done_is_val = (got_n % 2 == 0);
            end else begin
                timer--;
            end
        end
        tx_busy = force_busy | in_flight;
        @(negedge clock);
        check("fila_count", {{(32-CW){1'b0}}, fila_count}, mq.size());
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        dados_prontos = 1'b0;
        tx_done       = 1'b0;
        in_flight     = 1'b0;
        force_busy    = 1'b0;
        tx_busy       = 1'b0;
        done_is_val   = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_count", {{(32-CW){1'b0}}, fila_count}, 32'd0);
        check("rst_start", {31'd0, tx_start}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        mq.delete();
        exp_bytes.delete();
        got_n  = 0;
        m_prev = 1'b0;
        m_ovf  = 1'b0;
        reset  = 1'b1;
    endtask

    task automatic push_pair(input logic [7:0] c, input logic [7:0] v);
        dados_prontos    = 1'b1;
        response_command = c;
        response_value   = v;
        tick();
        dados_prontos = 1'b0;
        tick();
    endtask

    task automatic set_busy(input bit b);
        force_busy = b;
        tx_busy    = force_busy | in_flight;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((mq.size() != 0 || in_flight) && n < 400) begin
            tick();
            n++;
        end
        tick();
        tick();
        check(name, got_n, exp_bytes.size());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int starts;

        tbl[0] = '{cmd: 8'h45, val: 8'hAA, exp_cnt: 1, exp_ovf: 1'b0};
        tbl[1] = '{cmd: 8'hAA, val: 8'hFF, exp_cnt: 2, exp_ovf: 1'b0};
        tbl[2] = '{cmd: 8'hFF, val: 8'hAB, exp_cnt: 3, exp_ovf: 1'b0};
        tbl[3] = '{cmd: 8'hAB, val: 8'h45, exp_cnt: 4, exp_ovf: 1'b0};
        tbl[4] = '{cmd: 8'h5E, val: 8'hE5, exp_cnt: 4, exp_ovf: 1'b1};

        do_reset();

        // Single pair and first-transaction latency.
        dados_prontos    = 1'b1;
        response_command = 8'h09;
        response_value   = 8'h1A;
        tick();
        check("lat_cyc1_start", {31'd0, tx_start}, 32'd0);
        dados_prontos = 1'b0;
        tick();
        check("lat_cyc2_start", {31'd0, tx_start}, 32'd1);
        check("lat_cyc2_data", {24'd0, tx_data}, 32'h09);
        drain("single_pair");
        check("single_last", {24'd0, last_byte}, 32'h1A);
        check("single_count", {{(32-CW){1'b0}}, fila_count}, 32'd0);

        // Held level pushes once.
        base             = got_n;
        dados_prontos    = 1'b1;
        response_command = 8'h07;
        response_value   = 8'h55;
        repeat (50) tick();
        dados_prontos = 1'b0;
        drain("held_drain");
        check("held_bytes", got_n - base, 32'd2);

        // Overflow table with the UART held busy.
        set_busy(1'b1);
        for (int i = 0; i < 5; i++) begin
            push_pair(tbl[i].cmd, tbl[i].val);
            check("tbl_count", {{(32-CW){1'b0}}, fila_count}, tbl[i].exp_cnt);
            check("tbl_ovf", {31'd0, overflow}, {31'd0, tbl[i].exp_ovf});
        end
        set_busy(1'b0);
        drain("ovf_drain");
        check("ovf_last", {24'd0, last_byte}, 32'h45);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Push coincident with the pop of a full buffer.
        do_reset();
        set_busy(1'b1);
        for (int i = 0; i < 4; i++) push_pair(8'h10 + 8'(i), 8'h20 + 8'(i));
        set_busy(1'b0);
        n = 0;
        while (!(tx_done && done_is_val) && n < 200) begin
            tick();
            n++;
        end
        check("sim_reached", {31'd0, (tx_done && done_is_val)}, 32'd1);
        dados_prontos    = 1'b1;
        response_command = 8'h77;
        response_value   = 8'h88;
        tick();
        check("sim_count", {{(32-CW){1'b0}}, fila_count}, 32'd4);
        check("sim_ovf", {31'd0, overflow}, 32'd0);
        dados_prontos = 1'b0;
        drain("sim_drain");
        check("sim_last", {24'd0, last_byte}, 32'h88);

        // Busy gating of the value byte.
        base = got_n;
        push_pair(8'h0C, 8'h0D);
        n = 0;
        while (got_n != base + 1 && n < 50) begin
            tick();
            n++;
        end
        check("gate_cmd_seen", got_n - base, 32'd1);
        set_busy(1'b1);
        n = 0;
        while (in_flight && n < 50) begin
            tick();
            n++;
        end
        starts = 0;
        repeat (20) begin
            tick();
            starts += int'(tx_start);
        end
        check("gate_no_start", starts, 32'd0);
        set_busy(1'b0);
        tick();
        check("gate_val", {24'd0, last_byte}, 32'h0D);
        drain("gate_drain");

        // Reset while the command byte of three stored pairs is in flight.
        do_reset();
        set_busy(1'b1);
        for (int i = 0; i < 3; i++) push_pair(8'h30 + 8'(i), 8'h40 + 8'(i));
        set_busy(1'b0);
        n = 0;
        while (got_n != 1 && n < 50) begin
            tick();
            n++;
        end
        tick();
        check("midrst_cmd_seen", got_n, 32'd1);
        do_reset();
        repeat (30) tick();
        check("midrst_no_tx", got_n, 32'd0);
        check("midrst_count", {{(32-CW){1'b0}}, fila_count}, 32'd0);
        check("midrst_ovf", {31'd0, overflow}, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) dados_prontos = ~dados_prontos;
            response_command = 8'($urandom);
            response_value   = 8'($urandom);
            tick();
        end
        dados_prontos = 1'b0;
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fila_resposta_uart.md
FILA_RESPOSTA_UART -- requirements
Module: fila_resposta_uart

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of buffered response pairs (power of two, 2..16).
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port dados_prontos, input, 1 bit: level from the sensor stage; a rising edge marks a new response pair.
REQ-005 The block SHALL have port response_command, input, 8 bits: response code byte, sampled on the dados_prontos rising edge.
REQ-006 The block SHALL have port response_value, input, 8 bits: response data byte, sampled together with response_command.
REQ-007 The block SHALL have port tx_busy, input, 1 bit: UART transmitter currently shifting a byte.
REQ-008 The block SHALL have port tx_done, input, 1 bit: one-cycle pulse when the UART finishes a byte.
REQ-009 The block SHALL have port tx_start, output, 1 bit: one-cycle request to transmit tx_data.
REQ-010 The block SHALL have port tx_data, output, 8 bits: byte presented to the UART, stable from tx_start until the matching tx_done.
REQ-011 The block SHALL have port fila_count, output, clog2(DEPTH)+1 bits: number of stored pairs.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, a pair was dropped.

Function
REQ-013 Push SHALL occur on the clock edge where dados_prontos=1 and its registered previous value=0; a held-high level SHALL push exactly once.
REQ-014 Each push SHALL store {response_command, response_value} unmodified (0x45, 0xAA, 0xFF, 0xAB pass through as data).
REQ-015 Push while full with no pop that cycle SHALL drop the pair, leave contents unchanged and set overflow.
REQ-016 A push and pop in the same cycle SHALL both take effect, fila_count unchanged, no overflow even when full.
REQ-017 Pointers SHALL wrap modulo DEPTH; fila_count SHALL never exceed DEPTH or go below 0.
REQ-018 FSM states: OCIOSO, ENVIA_CMD, ESPERA_CMD, ENVIA_VAL, ESPERA_VAL.
REQ-019 OCIOSO: if fila_count>0 and tx_busy=0, go to ENVIA_CMD; else stay.
REQ-020 ENVIA_CMD: tx_start=1 for this cycle only, tx_data=head command byte; go to ESPERA_CMD.
REQ-021 ESPERA_CMD: on tx_done go to ENVIA_VAL; otherwise stay.
REQ-022 ENVIA_VAL: when tx_busy=0, assert tx_start one cycle with tx_data=head value byte, go to ESPERA_VAL; otherwise stay.
REQ-023 ESPERA_VAL: on tx_done pop the head pair and return to OCIOSO.
REQ-024 Bytes SHALL always go out in order command then value; pairs SHALL leave in push order.
REQ-025 Latency: an edge pushed into an empty buffer with tx_busy=0 SHALL produce tx_start two clock cycles after the push edge.
REQ-026 tx_done received in OCIOSO, ENVIA_CMD or ENVIA_VAL SHALL be ignored.

Reset
REQ-027 While reset=0: state OCIOSO, pointers and fila_count 0, tx_start 0, tx_data 0x00, overflow 0, edge register 0.
REQ-028 Reset mid-transmission SHALL discard all stored pairs and the byte in flight; no tx_start until a new push after release.
REQ-029 Only reset SHALL clear overflow.

Structure
REQ-030 State encoding and the byte width constant SHALL live in the shared package used by the sensor and UART modules.
REQ-031 Storage SHALL be one sub-module fila_sincrona (parameterised width 16, depth DEPTH, push/pop/count/full/empty).

Verification
REQ-032 Single pair: edge with cmd 0x09, val 0x1A, tx_busy=0 -> tx_start with 0x09, after tx_done tx_start with 0x1A, fila_count returns 0.
REQ-033 Held level: dados_prontos high 50 cycles with cmd 0x07 -> exactly one pair transmitted.
REQ-034 Overflow: DEPTH=4, five edges with tx_busy=1 -> fila_count=4, overflow=1, pairs 1..4 sent in order, fifth never sent.
REQ-035 Simultaneous: full buffer, push coincident with tx_done in ESPERA_VAL -> fila_count stays 4, overflow stays 0, new pair sent last.
REQ-036 Busy gating: tx_busy=1 in ENVIA_VAL for 20 cycles -> no tx_start until tx_busy drops, then value byte 0x0D.
REQ-037 Reset in ESPERA_CMD with 3 pairs stored -> fila_count=0, tx_start=0, overflow=0 after release, no further bytes sent.
